mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-lite datapath: sequences fetch/decode/execute/memory/writeback and drives the immediate-extender op (eop), ALU, register-file, PC and memory-port controls.
- Sits beside the datapath; consumes the IR contents, the ALU zero flag and a memory ready handshake.
- Supported: addu, subu, ori, lw, sw, beq, lui, j. Any other encoding is illegal.

Parameters:
- RET_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- instr  in  32  current IR contents (op=[31:26], funct=[5:0])
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (sw) when mem_req
- iord  out  1  0: address = PC, 1: address = ALUOut
- ir_wr  out  1  load IR
- pc_wr  out  1  unconditional PC write
- pc_wr_cond  out  1  PC write if zero
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump {PC[31:28],instr[25:0],2'b00}
- eop  out  2  extender op: 00 sign, 01 zero, 10 lui-high, 11 sign<<2
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext, 11 unused
- alu_op  out  2  00 add, 01 sub, 10 or
- reg_wr  out  1  register-file write
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired  out  RET_W  count of completed legal instructions

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB. Moore outputs from state + instr decode; all unlisted outputs 0.
- Reset (reset==0 at posedge): state=FETCH, retired=0. While reset is low all outputs read 0 (mem_req=0). Reset mid-memory-access abandons the request; the memory must tolerate withdrawn mem_req.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Hold until mem_ready; in the mem_ready cycle ir_wr=1, pc_wr=1, then -> DECODE. mem_req held stable until mem_ready.
- DECODE: eop=11, alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Legal -> EXEC; illegal -> illegal=1, -> FETCH, retired unchanged.
- EXEC per class:
  - R (addu/subu): alu_src_a=1, alu_src_b=00, alu_op=00/01 -> WB.
  - ori: eop=01, alu_src_a=1, alu_src_b=10, alu_op=10 -> WB.
  - lui: eop=10, alu_src_a=1, alu_src_b=10, alu_op=10 -> WB (datapath zeroes rs path for lui; alu_src_a=1 with rs=$0 per encoding).
  - lw/sw: eop=00, alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=01, pc_wr_cond=1, pc_src=01 -> FETCH, retired+1.
  - j: pc_wr=1, pc_src=10 -> FETCH, retired+1.
- MEM: mem_req=1, iord=1, mem_we=1 for sw. Wait for mem_ready. sw: on mem_ready -> FETCH, retired+1. lw: on mem_ready -> WB.
- WB: reg_wr=1; reg_dst=1 for R-type else 0; mem_to_reg=1 for lw. -> FETCH, retired+1.
- eop holds its EXEC value through MEM/WB for the same instruction; 00 elsewhere except DECODE.
- retired wraps modulo 2^RET_W.
- Latency without stalls: R/ori/lui/lw(4 incl. MEM→5 for lw) — R/ori/lui 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.

Decomposition:
- Shared package mc_pkg: state encoding, opcode/funct constants, EOP_*/ALU_*/PCSRC_* constants (EOP values match the extender encoding).
- One sub-module natural: mc_decode (combinational instr -> class one-hot + illegal).

Test Plan:
- reset low 3 cycles with mem_ready=1 -> mem_req=0, retired=0; release -> FETCH, mem_req=1 next cycle.
- addu $3,$1,$2 (0x00221821), mem_ready always 1 -> states F,D,E,W; WB reg_wr=1, reg_dst=1; retired=1 after 4 cycles.
- lw $2,8($1) (0x8C220008), mem_ready delayed 3 cycles in MEM -> mem_req/iord held 1 stable, eop=00 in EXEC, WB mem_to_reg=1; 8 cycles total.
- beq with zero=1 (0x1022FFFF) -> DECODE eop=11; EXEC pc_wr_cond=1, pc_src=01; back to FETCH, retired+1.
- lui $1,0x1234 (0x3C011234) then ori (0x34211234) -> EXEC eop=10 then 01.
- instr=0xFC000000 -> illegal pulse one cycle in DECODE, retired unchanged; reset asserted during MEM of sw -> FETCH, mem_we=0 next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the mc_ctrl multi-cycle control FSM
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Opcode field instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Function field instr[5:0] for R-type
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   // Immediate extender ops
   localparam logic [1:0] EOP_SIGN = 2'b00;
   localparam logic [1:0] EOP_ZERO = 2'b01;
   localparam logic [1:0] EOP_LUI  = 2'b10;
   localparam logic [1:0] EOP_SHL2 = 2'b11;

   // ALU ops
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;

   // PC source select
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_EXT  = 2'b10;

   // One-hot instruction class
   typedef struct packed {
      logic r_type;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
   } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction class decoder
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_t    cls,
   output logic       is_sub,
   output logic       illegal
);

   // Classify the instruction; anything not recognised is illegal
   always_comb begin
      cls     = '0;
      is_sub  = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_ADDU) begin
               cls.r_type = 1'b1;
            end else if (funct == FN_SUBU) begin
               cls.r_type = 1'b1;
               is_sub     = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_ORI:  cls.ori = 1'b1;
         OP_LUI:  cls.lui = 1'b1;
         OP_LW:   cls.lw  = 1'b1;
         OP_SW:   cls.sw  = 1'b1;
         OP_BEQ:  cls.beq = 1'b1;
         OP_J:    cls.j   = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb control FSM
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int RET_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic             pc_wr_cond,
   output logic [1:0]       pc_src,
   output logic [1:0]       eop,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_wr,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   state_t           state_q, state_d;
   logic [RET_W-1:0] retired_q, retired_d;
   iclass_t          cls;
   logic             is_sub;
   logic             dec_illegal;
   logic [1:0]       eop_instr;
   logic             unused_bits;

   // The branch decision is taken in the datapath via pc_wr_cond, so zero
   // and the register/immediate fields are not needed here
   assign unused_bits = ^{instr[25:6], zero};

   mc_decode u_decode (
      .op      (instr[31:26]),
      .funct   (instr[5:0]),
      .cls     (cls),
      .is_sub  (is_sub),
      .illegal (dec_illegal)
   );

   // Extender op used from EXEC onward; held for the whole instruction
   assign eop_instr = cls.ori ? EOP_ZERO : (cls.lui ? EOP_LUI : EOP_SIGN);

   // Retired count is hidden while reset is held
   assign retired = reset ? retired_q : '0;

   // Next-state, retirement and Moore control outputs
   always_comb begin
      state_d    = state_q;
      retired_d  = retired_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      pc_src     = PCSRC_ALU;
      eop        = EOP_SIGN;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_wr   = 1'b1;
               pc_wr   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute branch target into ALUOut
            eop       = EOP_SHL2;
            alu_src_b = SRCB_EXT;
            if (dec_illegal) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            eop = eop_instr;
            if (cls.r_type) begin
               alu_src_a = 1'b1;
               alu_op    = is_sub ? ALU_SUB : ALU_ADD;
               state_d   = S_WB;
            end else if (cls.ori || cls.lui) begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_EXT;
               alu_op    = ALU_OR;
               state_d   = S_WB;
            end else if (cls.lw || cls.sw) begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_EXT;
               state_d   = S_MEM;
            end else if (cls.beq) begin
               alu_src_a  = 1'b1;
               alu_op     = ALU_SUB;
               pc_wr_cond = 1'b1;
               pc_src     = PCSRC_OUT;
               retired_d  = retired_q + 1'b1;
               state_d    = S_FETCH;
            end else if (cls.j) begin
               pc_wr     = 1'b1;
               pc_src    = PCSRC_JUMP;
               retired_d = retired_q + 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            eop     = eop_instr;
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = cls.sw;
            if (mem_ready) begin
               if (cls.sw) begin
                  retired_d = retired_q + 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            eop        = eop_instr;
            reg_wr     = 1'b1;
            reg_dst    = cls.r_type;
            mem_to_reg = cls.lw;
            retired_d  = retired_q + 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // All controls are quiet while reset is held, withdrawing any request
      if (!reset) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         ir_wr      = 1'b0;
         pc_wr      = 1'b0;
         pc_wr_cond = 1'b0;
         pc_src     = PCSRC_ALU;
         eop        = EOP_SIGN;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_RT;
         alu_op     = ALU_ADD;
         reg_wr     = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         illegal    = 1'b0;
      end
   end

   // State and retired-counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - table-driven self-checking bench for mc_ctrl
module tb_mc_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_wr;
      logic       pc_wr;
      logic       pc_wr_cond;
      logic [1:0] pc_src;
      logic [1:0] eop;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic        rst_n;
      logic [31:0] instr;
      logic        zero;
      logic        rdy;
      ctl_t        exp;
      int          ret;
   } vec_t;

   localparam logic [31:0] I_ADDU = 32'h00221821;
   localparam logic [31:0] I_SUBU = 32'h00221823;
   localparam logic [31:0] I_LW   = 32'h8C220008;
   localparam logic [31:0] I_SW   = 32'hAC220008;
   localparam logic [31:0] I_BEQ  = 32'h1022FFFF;
   localparam logic [31:0] I_LUI  = 32'h3C011234;
   localparam logic [31:0] I_ORI  = 32'h34211234;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, iord, ir_wr, pc_wr, pc_wr_cond;
   logic [1:0]  pc_src, eop, alu_src_b, alu_op;
   logic        alu_src_a, reg_wr, reg_dst, mem_to_reg, illegal;
   logic [31:0] retired;
   ctl_t        act;

   int cmp_cnt = 0;
   int err_cnt = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mc_ctrl #(.RET_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_wr      (ir_wr),
      .pc_wr      (pc_wr),
      .pc_wr_cond (pc_wr_cond),
      .pc_src     (pc_src),
      .eop        (eop),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_wr     (reg_wr),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .retired    (retired)
   );

   assign act = {mem_req, mem_we, iord, ir_wr, pc_wr, pc_wr_cond, pc_src, eop,
                 alu_src_a, alu_src_b, alu_op, reg_wr, reg_dst, mem_to_reg, illegal};

   // Expected control bundles, written directly from the state descriptions
   function automatic ctl_t c_fetch(logic rdy);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_wr = rdy; c.pc_wr = rdy;
      return c;
   endfunction
   function automatic ctl_t c_dec(logic ill);
      ctl_t c = '0;
      c.eop = 2'b11; c.alu_src_b = 2'b10; c.illegal = ill;
      return c;
   endfunction
   function automatic ctl_t c_exec_r(logic sub);
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_op = sub ? 2'b01 : 2'b00;
      return c;
   endfunction
   function automatic ctl_t c_exec_imm(logic [1:0] e, logic [1:0] op);
      ctl_t c = '0;
      c.eop = e; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op;
      return c;
   endfunction
   function automatic ctl_t c_exec_beq();
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_wr_cond = 1'b1; c.pc_src = 2'b01;
      return c;
   endfunction
   function automatic ctl_t c_exec_j();
      ctl_t c = '0;
      c.pc_wr = 1'b1; c.pc_src = 2'b10;
      return c;
   endfunction
   function automatic ctl_t c_mem(logic we);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = we;
      return c;
   endfunction
   function automatic ctl_t c_wb(logic dst, logic m2r, logic [1:0] e);
      ctl_t c = '0;
      c.reg_wr = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r; c.eop = e;
      return c;
   endfunction

   task automatic add(logic r, logic [31:0] i, logic z, logic rdy, ctl_t e, int ret);
      vec_t v;
      v.rst_n = r; v.instr = i; v.zero = z; v.rdy = rdy; v.exp = e; v.ret = ret;
      vecs.push_back(v);
   endtask

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      cmp_cnt++;
      if (a !== e) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   initial begin
      int waited;
      // reset with mem_ready high
      for (int k = 0; k < 3; k++) add(0, I_ADDU, 0, 1, '0, 0);
      // addu: F D E W
      add(1, I_ADDU, 0, 1, c_fetch(1), 0);
      add(1, I_ADDU, 0, 1, c_dec(0), 0);
      add(1, I_ADDU, 0, 1, c_exec_r(0), 0);
      add(1, I_ADDU, 0, 1, c_wb(1, 0, 2'b00), 0);
      // lw with one fetch stall and three MEM stalls
      add(1, I_LW, 0, 0, c_fetch(0), 1);
      add(1, I_LW, 0, 1, c_fetch(1), 1);
      add(1, I_LW, 0, 1, c_dec(0), 1);
      add(1, I_LW, 0, 1, c_exec_imm(2'b00, 2'b00), 1);
      for (int k = 0; k < 3; k++) add(1, I_LW, 0, 0, c_mem(0), 1);
      add(1, I_LW, 0, 1, c_mem(0), 1);
      add(1, I_LW, 0, 1, c_wb(0, 1, 2'b00), 1);
      // beq taken
      add(1, I_BEQ, 1, 1, c_fetch(1), 2);
      add(1, I_BEQ, 1, 1, c_dec(0), 2);
      add(1, I_BEQ, 1, 1, c_exec_beq(), 2);
      // lui then ori
      add(1, I_LUI, 0, 1, c_fetch(1), 3);
      add(1, I_LUI, 0, 1, c_dec(0), 3);
      add(1, I_LUI, 0, 1, c_exec_imm(2'b10, 2'b10), 3);
      add(1, I_LUI, 0, 1, c_wb(0, 0, 2'b10), 3);
      add(1, I_ORI, 0, 1, c_fetch(1), 4);
      add(1, I_ORI, 0, 1, c_dec(0), 4);
      add(1, I_ORI, 0, 1, c_exec_imm(2'b01, 2'b10), 4);
      add(1, I_ORI, 0, 1, c_wb(0, 0, 2'b01), 4);
      // illegal: two cycles, count unchanged
      add(1, I_BAD, 0, 1, c_fetch(1), 5);
      add(1, I_BAD, 0, 1, c_dec(1), 5);
      // j
      add(1, I_J, 0, 1, c_fetch(1), 5);
      add(1, I_J, 0, 1, c_dec(0), 5);
      add(1, I_J, 0, 1, c_exec_j(), 5);
      // subu
      add(1, I_SUBU, 0, 1, c_fetch(1), 6);
      add(1, I_SUBU, 0, 1, c_dec(0), 6);
      add(1, I_SUBU, 0, 1, c_exec_r(1), 6);
      add(1, I_SUBU, 0, 1, c_wb(1, 0, 2'b00), 6);
      // sw completes
      add(1, I_SW, 0, 1, c_fetch(1), 7);
      add(1, I_SW, 0, 1, c_dec(0), 7);
      add(1, I_SW, 0, 1, c_exec_imm(2'b00, 2'b00), 7);
      add(1, I_SW, 0, 1, c_mem(1), 7);
      // sw abandoned by reset in MEM
      add(1, I_SW, 0, 1, c_fetch(1), 8);
      add(1, I_SW, 0, 1, c_dec(0), 8);
      add(1, I_SW, 0, 1, c_exec_imm(2'b00, 2'b00), 8);
      add(1, I_SW, 0, 0, c_mem(1), 8);
      add(0, I_SW, 0, 0, '0, 0);
      add(1, I_SW, 0, 0, c_fetch(0), 0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst_n; instr = vecs[i].instr;
         zero = vecs[i].zero; mem_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("ctl[%0d]", i), 64'(act), 64'(vecs[i].exp));
         chk($sformatf("retired[%0d]", i), 64'(retired), 64'(vecs[i].ret));
         @(posedge clk); #1;
      end

      // Fetch stall: request held stable for five cycles, then accepted
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_mem_req", 64'(mem_req), 64'd1);
         chk("stall_ir_wr", 64'(ir_wr), 64'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      waited = 0;
      while (waited < 4) begin
         @(negedge clk);
         if (ir_wr === 1'b1) break;
         waited++;
      end
      chk("fetch_accept_wait", 64'(waited), 64'd0);
      // Remaining sw cycles: DECODE, EXEC, MEM, then FETCH with count 1
      waited = 0;
      while (waited < 10 && retired !== 32'd1) begin
         @(posedge clk); #1;
         @(negedge clk);
         waited++;
      end
      chk("sw_after_reset_cycles", 64'(waited), 64'd4);
      chk("sw_after_reset_retired", 64'(retired), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
